// File: rtl/boot_run_ctrl_if.sv
// Environment <-> boot/run controller signal bundle.
// The environment uses the master modport, the controller uses the slave modport.
interface boot_run_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
);
    // in_start is a level, acted on only while the controller sits in IDLE or HALT;
    // there is no ready/ack, the environment simply holds it until out_done drops.
    logic                  in_start;
    logic                  in_done_load_inst;
    logic [DATA_WIDTH-1:0] in_boot_pc;
    logic [CNT_WIDTH-1:0]  in_max_cycles;
    logic [DATA_WIDTH-1:0] in_DM_addr;
    logic                  in_DM_wr_en;
    logic [DATA_WIDTH-1:0] in_DM_wr_data;

    logic                  out_core_Rst_N;
    logic [DATA_WIDTH-1:0] out_PC;
    logic                  out_load_init_addr;
    logic                  out_running;
    logic                  out_done;
    logic                  out_timeout;
    logic [DATA_WIDTH-1:0] out_exit_code;
    logic [CNT_WIDTH-1:0]  out_cycle_count;
    logic [2:0]            out_dbg_state;

    modport master (
        output in_start, in_done_load_inst, in_boot_pc, in_max_cycles,
               in_DM_addr, in_DM_wr_en, in_DM_wr_data,
        input  out_core_Rst_N, out_PC, out_load_init_addr, out_running,
               out_done, out_timeout, out_exit_code, out_cycle_count, out_dbg_state
    );

    modport slave (
        input  in_start, in_done_load_inst, in_boot_pc, in_max_cycles,
               in_DM_addr, in_DM_wr_en, in_DM_wr_data,
        output out_core_Rst_N, out_PC, out_load_init_addr, out_running,
               out_done, out_timeout, out_exit_code, out_cycle_count, out_dbg_state
    );
endinterface

// File: rtl/boot_run_ctrl.sv
// Boot/run sequencer for the RV64IF core: reset hold, initial-PC load, run-cycle count, tohost exit.
// Define BOOT_RUN_CTRL_TIMEOUT_EN to enforce the in_max_cycles run budget.
module boot_run_ctrl #(
    parameter int                    DATA_WIDTH      = 64,
    parameter int                    CNT_WIDTH       = 32,
    parameter int                    RST_HOLD_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] TOHOST_ADDR     = DATA_WIDTH'(64'h0000_0000_0001_1000)
) (
    input  logic           in_Clk,
    input  logic           Rst_N,
    boot_run_ctrl_if.slave bus
);
    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_LOAD, S_HOLD, S_LOAD_PC, S_RUN, S_HALT
    } state_t;

    state_t                r_state, w_next_state;
    logic [HOLD_W-1:0]     r_hold_cnt, w_nxt_hold_cnt;
    logic [DATA_WIDTH-1:0] r_pc, w_nxt_pc;
    logic [DATA_WIDTH-1:0] r_out_pc, w_nxt_out_pc;
    logic                  r_core_rst_n, w_nxt_core_rst_n;
    logic                  r_load, w_nxt_load;
    logic                  r_running, w_nxt_running;
    logic                  r_done, w_nxt_done;
    logic                  r_timeout, w_nxt_timeout;
    logic [DATA_WIDTH-1:0] r_exit_code, w_nxt_exit_code;
    logic [CNT_WIDTH-1:0]  r_cycle_count, w_nxt_cycle_count;

    logic                  w_start, w_exit, w_expire;
    logic [CNT_WIDTH-1:0]  w_cnt_plus1, w_cnt_sat;

    assign w_start     = bus.in_start && ((r_state == S_IDLE) || (r_state == S_HALT));
    assign w_exit      = (r_state == S_RUN) && bus.in_DM_wr_en && (bus.in_DM_addr == TOHOST_ADDR);
    assign w_cnt_plus1 = r_cycle_count + CNT_WIDTH'(1);
    assign w_cnt_sat   = (&r_cycle_count) ? r_cycle_count : w_cnt_plus1;

`ifdef BOOT_RUN_CTRL_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] r_budget;
    // Budget of 0 means unlimited; expiry lands exactly when the count reaches the budget.
    assign w_expire = (r_state == S_RUN) && (r_budget != '0) && (w_cnt_plus1 == r_budget);
    always_ff @(posedge in_Clk) begin
        if (!Rst_N)       r_budget <= '0;
        else if (w_start) r_budget <= bus.in_max_cycles;
    end
`else
    logic w_unused_budget;
    assign w_unused_budget = ^bus.in_max_cycles;
    assign w_expire        = 1'b0;
`endif

    always_ff @(posedge in_Clk) begin
        if (!Rst_N) begin
            r_state       <= S_IDLE;
            r_hold_cnt    <= '0;
            r_pc          <= '0;
            r_out_pc      <= '0;
            r_core_rst_n  <= 1'b0;
            r_load        <= 1'b0;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_exit_code   <= '0;
            r_cycle_count <= '0;
        end else begin
            r_state       <= w_next_state;
            r_hold_cnt    <= w_nxt_hold_cnt;
            r_pc          <= w_nxt_pc;
            r_out_pc      <= w_nxt_out_pc;
            r_core_rst_n  <= w_nxt_core_rst_n;
            r_load        <= w_nxt_load;
            r_running     <= w_nxt_running;
            r_done        <= w_nxt_done;
            r_timeout     <= w_nxt_timeout;
            r_exit_code   <= w_nxt_exit_code;
            r_cycle_count <= w_nxt_cycle_count;
        end
    end

    // HOLD is left once the counter has seen RST_HOLD_CYCLES hold edges, so the
    // load pulse appears RST_HOLD_CYCLES+1 edges after the load-done sample.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_start) w_next_state = S_WAIT_LOAD;
            S_WAIT_LOAD: if (bus.in_done_load_inst) w_next_state = S_HOLD;
            S_HOLD: begin
                if (!bus.in_done_load_inst)                    w_next_state = S_WAIT_LOAD;
                else if (r_hold_cnt == HOLD_W'(RST_HOLD_CYCLES)) w_next_state = S_LOAD_PC;
            end
            S_LOAD_PC:   w_next_state = S_RUN;
            S_RUN:       if (w_exit || w_expire) w_next_state = S_HALT;
            S_HALT:      if (w_start) w_next_state = S_WAIT_LOAD;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_nxt_hold_cnt    = '0;
        w_nxt_pc          = r_pc;
        w_nxt_out_pc      = r_out_pc;
        w_nxt_done        = r_done;
        w_nxt_timeout     = r_timeout;
        w_nxt_exit_code   = r_exit_code;
        w_nxt_cycle_count = r_cycle_count;
        w_nxt_core_rst_n  = (w_next_state == S_LOAD_PC) || (w_next_state == S_RUN);
        w_nxt_load        = (w_next_state == S_LOAD_PC);
        w_nxt_running     = (w_next_state == S_RUN);
        if ((r_state == S_HOLD) && (w_next_state == S_HOLD))
            w_nxt_hold_cnt = r_hold_cnt + HOLD_W'(1);
        if (w_start) begin
            w_nxt_pc          = bus.in_boot_pc;
            w_nxt_done        = 1'b0;
            w_nxt_timeout     = 1'b0;
            w_nxt_exit_code   = '0;
            w_nxt_cycle_count = '0;
        end
        if (w_next_state == S_LOAD_PC)
            w_nxt_out_pc = r_pc;
        // Exit takes priority over a budget expiry on the same edge.
        if (r_state == S_RUN) begin
            w_nxt_cycle_count = w_cnt_sat;
            if (w_exit) begin
                w_nxt_done      = 1'b1;
                w_nxt_exit_code = bus.in_DM_wr_data;
            end else if (w_expire) begin
                w_nxt_done      = 1'b1;
                w_nxt_timeout   = 1'b1;
                w_nxt_exit_code = '0;
            end
        end
    end

    assign bus.out_core_Rst_N     = r_core_rst_n;
    assign bus.out_PC             = r_out_pc;
    assign bus.out_load_init_addr = r_load;
    assign bus.out_running        = r_running;
    assign bus.out_done           = r_done;
    assign bus.out_timeout        = r_timeout;
    assign bus.out_exit_code      = r_exit_code;
    assign bus.out_cycle_count    = r_cycle_count;
    assign bus.out_dbg_state      = r_state;
endmodule

// File: tb/tb_boot_run_ctrl.sv
// Bench for boot_run_ctrl: boot vector table, hand-written exit/halt sequences, randomized runs
// checked against a run-level model (load latency, end cycle, exit vs. timeout outcome).
module tb_boot_run_ctrl;
    localparam int          HOLD   = 2;
    localparam logic [63:0] TOHOST = 64'h0000_0000_0001_1000;
    localparam logic [63:0] BOOT   = 64'h10570;
`ifdef BOOT_RUN_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    boot_run_ctrl_if #(.DATA_WIDTH(64), .CNT_WIDTH(32)) bus ();

    boot_run_ctrl #(
        .DATA_WIDTH(64), .CNT_WIDTH(32), .RST_HOLD_CYCLES(HOLD), .TOHOST_ADDR(TOHOST)
    ) dut (
        .in_Clk (clk),
        .Rst_N  (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        rst_n, start, done_ld;
        logic        e_core_rst_n, e_load, e_running, e_done, e_pc_valid;
        logic [31:0] e_cnt;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(logic r, logic s, logic d, logic ecr, logic eld,
                                logic erun, logic edn, logic epc, logic [31:0] ecnt);
        vec_t v;
        v.rst_n = r; v.start = s; v.done_ld = d;
        v.e_core_rst_n = ecr; v.e_load = eld; v.e_running = erun;
        v.e_done = edn; v.e_pc_valid = epc; v.e_cnt = ecnt;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_core_rst_n"}, 64'(bus.out_core_Rst_N), 64'd0);
        chk({tag, "_load"},       64'(bus.out_load_init_addr), 64'd0);
        chk({tag, "_running"},    64'(bus.out_running), 64'd0);
        chk({tag, "_done"},       64'(bus.out_done), 64'd0);
        chk({tag, "_timeout"},    64'(bus.out_timeout), 64'd0);
        chk({tag, "_exit"},       bus.out_exit_code, 64'd0);
        chk({tag, "_count"},      64'(bus.out_cycle_count), 64'd0);
        chk({tag, "_pc"},         bus.out_PC, 64'd0);
    endtask

    // One full run from IDLE/HALT; expectations come from the run-level rules only.
    task automatic do_run(input logic [63:0] pc, input logic [31:0] budget, input int store_at,
                          input logic [63:0] data, input int drop_after, input int delay);
        int lat;
        int end_at;
        int decoy;
        bit exp_to;
        bus.in_start = 1'b1; bus.in_boot_pc = pc; bus.in_max_cycles = budget;
        bus.in_done_load_inst = 1'b0;
        tick();
        bus.in_start = 1'b0; bus.in_boot_pc = ~pc; bus.in_max_cycles = ~budget;
        chk("start_done", 64'(bus.out_done), 64'd0);
        chk("start_count", 64'(bus.out_cycle_count), 64'd0);
        chk("start_exit", bus.out_exit_code, 64'd0);
        chk("start_core_rst_n", 64'(bus.out_core_Rst_N), 64'd0);
        repeat (delay) tick();
        bus.in_done_load_inst = 1'b1;
        tick();
        if (drop_after > 0) begin
            for (int i = 1; i < drop_after; i++) begin
                tick();
                chk("hold_no_load", 64'(bus.out_load_init_addr), 64'd0);
            end
            bus.in_done_load_inst = 1'b0;
            tick();
            chk("drop_no_load", 64'(bus.out_load_init_addr), 64'd0);
            chk("drop_core_rst_n", 64'(bus.out_core_Rst_N), 64'd0);
            bus.in_done_load_inst = 1'b1;
            tick();
        end
        lat = 0;
        while (bus.out_load_init_addr !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("load_latency", 64'(lat), 64'(HOLD + 1));
        chk("load_pc", bus.out_PC, pc);
        chk("load_core_rst_n", 64'(bus.out_core_Rst_N), 64'd1);
        tick();
        chk("run_entry_load", 64'(bus.out_load_init_addr), 64'd0);
        chk("run_entry_running", 64'(bus.out_running), 64'd1);
        chk("run_entry_count", 64'(bus.out_cycle_count), 64'd0);

        exp_to = TIMEOUT_EN && (budget != 0) && (int'(budget) < store_at);
        end_at = exp_to ? int'(budget) : store_at;
        decoy  = $urandom_range(1, end_at);
        for (int c = 1; c <= end_at; c++) begin
            bus.in_DM_wr_en = 1'b0; bus.in_DM_addr = TOHOST; bus.in_DM_wr_data = {$urandom, $urandom};
            if (c == store_at) begin
                bus.in_DM_wr_en = 1'b1; bus.in_DM_wr_data = data;
            end else if (c == decoy) begin
                bus.in_DM_wr_en = 1'b1; bus.in_DM_addr = TOHOST + 64'h8;
            end
            tick();
            if (c < end_at) begin
                chk("run_count", 64'(bus.out_cycle_count), 64'(c));
                chk("run_running", 64'(bus.out_running), 64'd1);
            end
        end
        bus.in_DM_wr_en = 1'b0;
        chk("end_done", 64'(bus.out_done), 64'd1);
        chk("end_running", 64'(bus.out_running), 64'd0);
        chk("end_core_rst_n", 64'(bus.out_core_Rst_N), 64'd0);
        chk("end_timeout", 64'(bus.out_timeout), 64'(exp_to));
        chk("end_exit", bus.out_exit_code, exp_to ? 64'd0 : data);
        chk("end_count", 64'(bus.out_cycle_count), 64'(end_at));
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        bus.in_start = 1'b0; bus.in_done_load_inst = 1'b0;
        bus.in_boot_pc = BOOT; bus.in_max_cycles = '0;
        bus.in_DM_addr = TOHOST; bus.in_DM_wr_en = 1'b0; bus.in_DM_wr_data = '0;

        // Boot table: scenario 1, reset mid-RUN, then a load-done drop during HOLD.
        add(1,1,0, 0,0,0,0,0, 0);
        for (int i = 0; i < 10; i++) add(1,0,0, 0,0,0,0,0, 0);
        for (int i = 0; i < 3; i++)  add(1,0,1, 0,0,0,0,0, 0);
        add(1,0,1, 1,1,0,0,1, 0);
        add(1,0,1, 1,0,1,0,1, 0);
        add(1,0,1, 1,0,1,0,1, 1);
        add(0,0,1, 0,0,0,0,0, 0);
        add(1,0,0, 0,0,0,0,0, 0);
        add(1,1,0, 0,0,0,0,0, 0);
        add(1,0,1, 0,0,0,0,0, 0);
        add(1,0,1, 0,0,0,0,0, 0);
        add(1,0,0, 0,0,0,0,0, 0);
        add(1,0,0, 0,0,0,0,0, 0);
        for (int i = 0; i < 3; i++)  add(1,0,1, 0,0,0,0,0, 0);
        add(1,0,1, 1,1,0,0,1, 0);
        add(1,0,1, 1,0,1,0,1, 0);

        repeat (3) tick();
        chk_idle_outputs("reset");
        chk("reset_state", 64'(bus.out_dbg_state), 64'd0);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            bus.in_start = vecs[i].start;
            bus.in_done_load_inst = vecs[i].done_ld;
            tick();
            chk($sformatf("vec%0d_core_rst_n", i), 64'(bus.out_core_Rst_N), 64'(vecs[i].e_core_rst_n));
            chk($sformatf("vec%0d_load", i), 64'(bus.out_load_init_addr), 64'(vecs[i].e_load));
            chk($sformatf("vec%0d_running", i), 64'(bus.out_running), 64'(vecs[i].e_running));
            chk($sformatf("vec%0d_done", i), 64'(bus.out_done), 64'(vecs[i].e_done));
            chk($sformatf("vec%0d_timeout", i), 64'(bus.out_timeout), 64'd0);
            chk($sformatf("vec%0d_exit", i), bus.out_exit_code, 64'd0);
            chk($sformatf("vec%0d_count", i), 64'(bus.out_cycle_count), 64'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_pc", i), bus.out_PC, vecs[i].e_pc_valid ? BOOT : 64'd0);
        end
        bus.in_start = 1'b0;

        // Scenario 2: decoy store at cycle 20, tohost store of 0x2A at run cycle 50.
        for (int c = 1; c < 50; c++) begin
            bus.in_DM_wr_en = (c == 20); bus.in_DM_addr = (c == 20) ? 64'h11008 : TOHOST;
            bus.in_DM_wr_data = 64'hDEAD;
            tick();
            if (c == 20 || c == 49) chk("s2_count", 64'(bus.out_cycle_count), 64'(c));
        end
        bus.in_DM_wr_en = 1'b1; bus.in_DM_addr = TOHOST; bus.in_DM_wr_data = 64'h2A;
        tick();
        bus.in_DM_wr_en = 1'b0;
        chk("s2_done", 64'(bus.out_done), 64'd1);
        chk("s2_exit", bus.out_exit_code, 64'h2A);
        chk("s2_count", 64'(bus.out_cycle_count), 64'd50);
        chk("s2_running", 64'(bus.out_running), 64'd0);
        chk("s2_core_rst_n", 64'(bus.out_core_Rst_N), 64'd0);

        // HALT holds its outputs regardless of load-done or stray stores.
        for (int i = 0; i < 4; i++) begin
            bus.in_done_load_inst = i[0];
            bus.in_DM_wr_en = 1'b1; bus.in_DM_wr_data = 64'h55;
            tick();
            chk("halt_done", 64'(bus.out_done), 64'd1);
            chk("halt_count", 64'(bus.out_cycle_count), 64'd50);
            chk("halt_exit", bus.out_exit_code, 64'h2A);
            chk("halt_core_rst_n", 64'(bus.out_core_Rst_N), 64'd0);
        end
        bus.in_DM_wr_en = 1'b0;

        // Restart from HALT, budget scenario, and exit/expiry tie.
        do_run(BOOT, 32'd0, 5, 64'h1234, 0, 2);
        do_run(64'h2000, 32'd500, 600, 64'h99, 0, 1);
        do_run(64'h3000, 32'd100, 100, 64'h7, 0, 0);
        do_run(64'h4000, 32'd0, 30, 64'hABCD, 1, 3);

        for (int r = 0; r < 12; r++) begin
            logic [31:0] bud;
            bud = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
            do_run({$urandom, $urandom}, bud, $urandom_range(1, 300), {$urandom, $urandom},
                   $urandom_range(0, HOLD), $urandom_range(0, 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
